alarm_sequencer: RTL

Downstream consumer of the packed per-object counter bus (`status`, N fields of W bits) that drives the single buzzer output. It detects each object entering value 0 (wrap from 9), latches these as pending alarms, and serves them one at a time, lowest index first. Each alarm is played as (index+1) tone bursts, so the operator can identify which object wrapped. It replaces the per-object OR-ed buzzers with one arbitrated, self-timed alarm path.

---
 rtl/alarm_pkg.sv | 25 ++
 rtl/alarm_sequencer_tone_gen.sv | 50 +++++
 rtl/alarm_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared types and sizing helpers for the alarm sequencer and its tone generator.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEEP  = 2'd1,
        GAP   = 2'd2,
        PAUSE = 2'd3
    } state_e;

    // Width needed to hold an index in 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/alarm_sequencer_tone_gen.sv
// Square-wave toggler: TONE_DIV cycles per half-period while run_i is high,
// restarted high on restart_i; tone_d_o is the value the tone takes at the next edge.
module tone_gen #(
    parameter int TONE_DIV = 25000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic restart_i,
    input  logic run_i,
    output logic tone_d_o
);

    localparam int CW = $clog2(TONE_DIV + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tone_q;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        cnt_d    = cnt_q;
        tone_d_o = tone_q;
        if (clear_i) begin
            cnt_d    = '0;
            tone_d_o = 1'b0;
        end else if (restart_i) begin
            cnt_d    = '0;
            tone_d_o = 1'b1;
        end else if (run_i) begin
            if (cnt_q == CW'(TONE_DIV - 1)) begin
                cnt_d    = '0;
                tone_d_o = ~tone_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d_o;
        end
    end

endmodule

// File: rtl/alarm_sequencer.sv
// Latches zero-entry events from the packed counter bus and plays each pending
// alarm, lowest index first, as (index+1) tone bursts on a single buzzer.
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int N         = 10,
    parameter int W         = 4,
    parameter int TONE_DIV  = 25000,
    parameter int BEEP_LEN  = 5000000,
    parameter int GAP_LEN   = 5000000,
    parameter int PAUSE_LEN = 15000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    clear,
    input  logic [N*W-1:0]          status,
    output logic                    buzzer_pin,
    output logic                    active,
    output logic [idx_width(N)-1:0] cur_index,
    output logic [N-1:0]            pending
);

    localparam int IW    = idx_width(N);
    localparam int BW    = $clog2(N + 1);
    localparam int DUR_W = $clog2(max4(BEEP_LEN, GAP_LEN, PAUSE_LEN, TONE_DIV) + 1);

    state_e           state_q;
    logic [DUR_W-1:0] dur_q, dur_inc;
    logic [BW-1:0]    burst_q;
    logic [IW-1:0]    cur_index_q, low_idx;
    logic [N*W-1:0]   prev_q;
    logic [N-1:0]     pending_q, events, svc_mask;
    logic             active_q, buzzer_q, tone_d;
    logic             take, beep_done, gap_done, pause_done, enter_beep, beep_next, last_burst;

    always_comb begin
        events = '0;
        for (int k = 0; k < N; k++) begin
            events[k] = enable && (prev_q[k*W +: W] != '0) && (status[k*W +: W] == '0);
        end
    end

    always_comb begin
        low_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (pending_q[k]) low_idx = IW'(k);
        end
    end

    assign take       = (state_q == IDLE) && (pending_q != '0);
    assign svc_mask   = take ? (N'(1) << low_idx) : '0;
    assign beep_done  = (state_q == BEEP)  && (dur_q == DUR_W'(BEEP_LEN - 1));
    assign gap_done   = (state_q == GAP)   && (dur_q == DUR_W'(GAP_LEN - 1));
    assign pause_done = (state_q == PAUSE) && (dur_q == DUR_W'(PAUSE_LEN - 1));
    assign enter_beep = take || gap_done;
    assign beep_next  = enter_beep || ((state_q == BEEP) && !beep_done);
    assign last_burst = (burst_q == BW'(cur_index_q) + BW'(1));
    assign dur_inc    = (dur_q == {DUR_W{1'b1}}) ? dur_q : dur_q + DUR_W'(1);

    // A new event on the bit being taken for service wins, so a re-wrap is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q    <= '0;
            pending_q <= '0;
        end else begin
            prev_q <= status;
            if (clear) pending_q <= '0;
            else       pending_q <= (pending_q & ~svc_mask) | events;
        end
    end

    tone_gen #(
        .TONE_DIV (TONE_DIV)
    ) u_tone (
        .clk       (clk),
        .rst_n     (rst),
        .clear_i   (clear),
        .restart_i (enter_beep),
        .run_i     (state_q == BEEP),
        .tone_d_o  (tone_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            dur_q       <= '0;
            burst_q     <= '0;
            cur_index_q <= '0;
            active_q    <= 1'b0;
            buzzer_q    <= 1'b0;
        end else if (clear) begin
            state_q  <= IDLE;
            dur_q    <= '0;
            burst_q  <= '0;
            active_q <= 1'b0;
            buzzer_q <= 1'b0;
        end else begin
            buzzer_q <= tone_d && beep_next;
            unique case (state_q)
                IDLE: begin
                    if (take) begin
                        state_q     <= BEEP;
                        cur_index_q <= low_idx;
                        burst_q     <= BW'(1);
                        dur_q       <= '0;
                        active_q    <= 1'b1;
                    end
                end
                BEEP: begin
                    if (beep_done) begin
                        dur_q   <= '0;
                        state_q <= last_burst ? PAUSE : GAP;
                    end else begin
                        dur_q <= dur_inc;
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        dur_q   <= '0;
                        state_q <= BEEP;
                        burst_q <= (burst_q == BW'(N)) ? burst_q : burst_q + BW'(1);
                    end else begin
                        dur_q <= dur_inc;
                    end
                end
                PAUSE: begin
                    if (pause_done) begin
                        dur_q    <= '0;
                        state_q  <= IDLE;
                        active_q <= 1'b0;
                    end else begin
                        dur_q <= dur_inc;
                    end
                end
            endcase
        end
    end

    assign buzzer_pin = buzzer_q;
    assign active     = active_q;
    assign cur_index  = cur_index_q;
    assign pending    = pending_q;

endmodule
